// File: rtl/fib_fsmd_if.sv
// Start/index/ready/done/result bundle between a controller and the fib_fsmd
// Fibonacci co-processor.
interface fib_fsmd_if #(
    parameter int IW = 5,
    parameter int FW = 20
);
    logic          start;
    logic [IW-1:0] i;
    logic          ready;
    logic          done_tick;
    logic [FW-1:0] f;

    modport master (
        output start,
        output i,
        input  ready,
        input  done_tick,
        input  f
    );

    modport slave (
        input  start,
        input  i,
        output ready,
        output done_tick,
        output f
    );
endinterface

// File: rtl/fib_fsmd.sv
// Iterative Fibonacci FSMD: one addition per clock, done_tick pulse at the end.
// Optional FIB_SATURATE_EN: additions saturate at all-ones instead of wrapping.
module fib_fsmd #(
    parameter int IW = 5,
    parameter int FW = 20
) (
    input  logic       clk,
    input  logic       reset,
    fib_fsmd_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_OP   = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t        state_r;
    logic [IW-1:0] n_r;
    logic [FW-1:0] t0_r;
    logic [FW-1:0] t1_r;
    logic          ready_r;
    logic          done_tick_r;

    // One Fibonacci step; saturating variant clamps on carry-out.
    function automatic logic [FW-1:0] fib_step(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
`ifdef FIB_SATURATE_EN
        if (sum_s[FW]) begin
            return {FW{1'b1}};
        end else begin
            return sum_s[FW-1:0];
        end
`else
        return sum_s[FW-1:0];
`endif
    endfunction

    assign bus.ready     = ready_r;
    assign bus.done_tick = done_tick_r;
    assign bus.f         = t1_r;

    // Controller and datapath; ready/done_tick registered with the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            n_r         <= {IW{1'b0}};
            t0_r        <= {FW{1'b0}};
            t1_r        <= {FW{1'b0}};
            ready_r     <= 1'b1;
            done_tick_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        n_r         <= bus.i;
                        t0_r        <= {FW{1'b0}};
                        t1_r        <= {{(FW-1){1'b0}}, 1'b1};
                        state_r     <= S_OP;
                        ready_r     <= 1'b0;
                        done_tick_r <= 1'b0;
                    end else begin
                        ready_r     <= 1'b1;
                        done_tick_r <= 1'b0;
                    end
                end
                S_OP: begin
                    if (n_r == {IW{1'b0}}) begin
                        t1_r        <= {FW{1'b0}};
                        state_r     <= S_DONE;
                        ready_r     <= 1'b0;
                        done_tick_r <= 1'b1;
                    end else if (n_r == IW'(1)) begin
                        state_r     <= S_DONE;
                        ready_r     <= 1'b0;
                        done_tick_r <= 1'b1;
                    end else begin
                        t1_r        <= fib_step(t1_r, t0_r);
                        t0_r        <= t1_r;
                        n_r         <= n_r - IW'(1);
                        ready_r     <= 1'b0;
                        done_tick_r <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_r     <= S_IDLE;
                    ready_r     <= 1'b1;
                    done_tick_r <= 1'b0;
                end
                default: begin
                    state_r     <= S_IDLE;
                    ready_r     <= 1'b1;
                    done_tick_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_fsmd.sv
// Directed bench for fib_fsmd: table of single jobs plus reset, back-to-back
// and abort sequences.
module tb_fib_fsmd;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fib_fsmd_if #(.IW(5), .FW(20)) bus ();

    fib_fsmd #(.IW(5), .FW(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [19:0] exp_f;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: wide Fibonacci, then wrap or clamp to 20 bits.
    function automatic logic [19:0] fib_ref(input int n);
        longint a, b, t;
        a = 64'd0;
        b = 64'd1;
        if (n == 0) return 20'd0;
        for (int k = 2; k <= n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
`ifdef FIB_SATURATE_EN
        if (b > 64'hFFFFF) b = 64'hFFFFF;
`else
        b = b & 64'hFFFFF;
`endif
        return b[19:0];
    endfunction

    task automatic run_job(input int idx, input logic [19:0] exp_f, input int exp_lat, input string tag);
        int cyc;
        bus.start = 1'b1;
        bus.i     = 5'(idx);
        tick();
        bus.start = 1'b0;
        bus.i     = 5'(~idx);
        check({tag, "_busy"}, {31'd0, bus.ready}, 32'd0);
        cyc = 1;
        while (!bus.done_tick && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_f"}, {12'd0, bus.f}, {12'd0, exp_f});
        tick();
        check({tag, "_pulse_end"}, {31'd0, bus.done_tick}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, bus.ready}, 32'd1);
        check({tag, "_f_held"}, {12'd0, bus.f}, {12'd0, exp_f});
    endtask

    logic [19:0] pend_f;
    int          pend_lat, acc_c, jobs;
    bit          pend_valid, want_ready;
    int          done_seen;

    task automatic observe(input int now);
        if (want_ready) begin
            check("b2b_idle_gap", {31'd0, bus.ready}, 32'd1);
            want_ready = 1'b0;
        end
        if (bus.done_tick) begin
            check("b2b_valid", {31'd0, pend_valid}, 32'd1);
            check("b2b_f", {12'd0, bus.f}, {12'd0, pend_f});
            check("b2b_latency", now - acc_c, pend_lat);
            pend_valid = 1'b0;
            want_ready = 1'b1;
            jobs++;
        end
    endtask

    initial begin
        vecs[0] = '{5'd0,  20'd0,      2};
        vecs[1] = '{5'd1,  20'd1,      2};
        vecs[2] = '{5'd2,  20'd1,      3};
        vecs[3] = '{5'd5,  20'd5,      6};
        vecs[4] = '{5'd10, 20'd55,     11};
        vecs[5] = '{5'd20, 20'd6765,   21};
        vecs[6] = '{5'd30, 20'd832040, 31};
`ifdef FIB_SATURATE_EN
        vecs[7] = '{5'd31, 20'hFFFFF,  32};
`else
        vecs[7] = '{5'd31, 20'd297693, 32};
`endif

        // Reset with start asserted: must stay idle.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.i     = 5'd5;
        tick();
        tick();
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_done", {31'd0, bus.done_tick}, 32'd0);
        check("rst_f", {12'd0, bus.f}, 32'd0);
        bus.start = 1'b0;
        reset     = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, bus.ready}, 32'd1);
        check("post_rst_f", {12'd0, bus.f}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            run_job(int'(vecs[v].idx), vecs[v].exp_f, vecs[v].exp_lat, $sformatf("job_i%0d", vecs[v].idx));
        end

        // start held high while i steps every two cycles.
        pend_valid = 1'b0;
        want_ready = 1'b0;
        jobs       = 0;
        acc_c      = 0;
        bus.start  = 1'b1;
        for (int c = 0; c < 64; c++) begin
            bus.i = 5'((c / 2) % 32);
            if (bus.ready) begin
                pend_f     = fib_ref(int'(bus.i));
                pend_lat   = ((bus.i == 5'd0) ? 1 : int'(bus.i)) + 1;
                acc_c      = c;
                pend_valid = 1'b1;
            end
            tick();
            observe(c + 1);
        end
        bus.start = 1'b0;
        for (int k = 0; k < 40 && pend_valid; k++) begin
            tick();
            observe(65 + k);
        end
        check("b2b_drained", {31'd0, pend_valid}, 32'd0);
        check("b2b_some_jobs", {31'd0, (jobs >= 5)}, 32'd1);
        tick();

        // Abort i=25 mid-computation with reset.
        bus.start = 1'b1;
        bus.i     = 5'd25;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        check("abort_done", {31'd0, bus.done_tick}, 32'd0);
        check("abort_f", {12'd0, bus.f}, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 35; k++) begin
            tick();
            if (bus.done_tick) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_job(7, 20'd13, 8, "after_abort_i7");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
